// File: rtl/marker_bbox_tracker.sv
// Red/blue colour-marker tracker: builds a per-frame bounding box for each player from the
// camera pixel stream and commits the boxes to the game logic at every frame end.
module marker_bbox_tracker #(
   parameter logic [7:0]  TH_HI       = 8'd160,
   parameter logic [7:0]  TH_LO       = 8'd90,
   parameter int          MIN_PIX     = 16,
   parameter int          LOST_FRAMES = 4,
   parameter logic [10:0] DEFAULT_POS = 11'd200
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_pix_valid,
   input  logic [10:0]      i_x,
   input  logic [10:0]      i_y,
   input  logic [7:0]       i_R,
   input  logic [7:0]       i_G,
   input  logic [7:0]       i_B,
   input  logic             i_frame_end,
   output logic [1:0][10:0] o_left,
   output logic [1:0][10:0] o_right,
   output logic [1:0][10:0] o_up,
   output logic [1:0][10:0] o_down,
   output logic [1:0]       o_lost,
   output logic             o_predict_valid
);

   localparam logic [10:0] X_MAX    = 11'd639;
   localparam logic [10:0] Y_MAX    = 11'd479;
   localparam logic [10:0] MIN_INIT = 11'h7FF;
   localparam logic [18:0] CNT_MAX  = '1;
   localparam logic [18:0] MIN_CNT  = 19'(MIN_PIX);
   localparam logic [2:0]  LOST_MAX = 3'(LOST_FRAMES);

   typedef enum logic {
      SYNC,
      ACCUM
   } state_t;

   state_t           r_state;
   state_t           w_stateNxt;
   logic             w_commit;
   logic             w_inRange;
   logic [1:0]       w_match;
   logic [1:0]       w_hit;
   logic [1:0]       w_detect;

   logic [1:0][10:0] r_minX;
   logic [1:0][10:0] r_maxX;
   logic [1:0][10:0] r_minY;
   logic [1:0][10:0] r_maxY;
   logic [1:0][18:0] r_cnt;
   logic [1:0][10:0] w_minXNxt;
   logic [1:0][10:0] w_maxXNxt;
   logic [1:0][10:0] w_minYNxt;
   logic [1:0][10:0] w_maxYNxt;
   logic [1:0][18:0] w_cntNxt;
   logic [1:0][2:0]  r_miss;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= SYNC;
      end else begin
         r_state <= w_stateNxt;
      end
   end

   // The first frame end after reset only aligns us to the frame; later ones commit.
   always_comb begin
      w_stateNxt = r_state;
      w_commit   = 1'b0;
      case (r_state)
         SYNC: begin
            if (i_frame_end) begin
               w_stateNxt = ACCUM;
            end
         end
         ACCUM: begin
            w_commit = i_frame_end;
         end
         default: w_stateNxt = SYNC;
      endcase
   end

   assign w_match[0] = (i_R >= TH_HI) && (i_G <= TH_LO) && (i_B <= TH_LO);
   assign w_match[1] = (i_B >= TH_HI) && (i_R <= TH_LO) && (i_G <= TH_LO);
   assign w_inRange  = (i_x <= X_MAX) && (i_y <= Y_MAX);
   assign w_hit      = (i_pix_valid && w_inRange && (r_state == ACCUM)) ? w_match : 2'b00;

   // Next accumulator values include the current pixel, so a frame-end pixel still counts.
   always_comb begin
      w_minXNxt = r_minX;
      w_maxXNxt = r_maxX;
      w_minYNxt = r_minY;
      w_maxYNxt = r_maxY;
      w_cntNxt  = r_cnt;
      w_detect  = 2'b00;
      for (int k = 0; k < 2; k++) begin
         if (w_hit[k]) begin
            if (i_x < r_minX[k]) w_minXNxt[k] = i_x;
            if (i_x > r_maxX[k]) w_maxXNxt[k] = i_x;
            if (i_y < r_minY[k]) w_minYNxt[k] = i_y;
            if (i_y > r_maxY[k]) w_maxYNxt[k] = i_y;
            if (r_cnt[k] != CNT_MAX) w_cntNxt[k] = r_cnt[k] + 19'd1;
         end
         w_detect[k] = (w_cntNxt[k] >= MIN_CNT);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || w_commit) begin
         r_minX <= {2{MIN_INIT}};
         r_maxX <= '0;
         r_minY <= {2{MIN_INIT}};
         r_maxY <= '0;
         r_cnt  <= '0;
      end else begin
         r_minX <= w_minXNxt;
         r_maxX <= w_maxXNxt;
         r_minY <= w_minYNxt;
         r_maxY <= w_maxYNxt;
         r_cnt  <= w_cntNxt;
      end
   end

   // A weak frame keeps the old box; only the miss that reaches the limit reverts it.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_left          <= {2{DEFAULT_POS}};
         o_right         <= {2{DEFAULT_POS}};
         o_up            <= {2{DEFAULT_POS}};
         o_down          <= {2{DEFAULT_POS}};
         o_lost          <= 2'b00;
         o_predict_valid <= 1'b0;
         r_miss          <= '0;
      end else begin
         o_predict_valid <= w_commit;
         if (w_commit) begin
            for (int k = 0; k < 2; k++) begin
               if (w_detect[k]) begin
                  o_left[k]  <= w_minXNxt[k];
                  o_right[k] <= w_maxXNxt[k];
                  o_up[k]    <= w_minYNxt[k];
                  o_down[k]  <= w_maxYNxt[k];
                  r_miss[k]  <= 3'd0;
                  o_lost[k]  <= 1'b0;
               end else if (r_miss[k] < LOST_MAX) begin
                  r_miss[k] <= r_miss[k] + 3'd1;
                  if ((r_miss[k] + 3'd1) == LOST_MAX) begin
                     o_left[k]  <= DEFAULT_POS;
                     o_right[k] <= DEFAULT_POS;
                     o_up[k]    <= DEFAULT_POS;
                     o_down[k]  <= DEFAULT_POS;
                     o_lost[k]  <= 1'b1;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_marker_bbox_tracker.sv
// Bench for marker_bbox_tracker: a table of frames with hand-computed boxes, corner-case
// sequences, and random frames checked every cycle against a pixel-list reference model.
module tb_marker_bbox_tracker;

   localparam int MIN_PIX     = 16;
   localparam int LOST_FRAMES = 4;
   localparam int DEF         = 200;

   logic             clk = 1'b0;
   logic             rst;
   logic             pixValid;
   logic [10:0]      px;
   logic [10:0]      py;
   logic [7:0]       pr;
   logic [7:0]       pg;
   logic [7:0]       pb;
   logic             frameEnd;
   logic [1:0][10:0] oLeft;
   logic [1:0][10:0] oRight;
   logic [1:0][10:0] oUp;
   logic [1:0][10:0] oDown;
   logic [1:0]       oLost;
   logic             oPredictValid;

   int checks = 0;
   int errors = 0;

   int mLeft[2];
   int mRight[2];
   int mUp[2];
   int mDown[2];
   int mMiss[2];
   int mLost[2];
   int mPulse;
   bit mSync;
   int qx0[$];
   int qy0[$];
   int qx1[$];
   int qy1[$];

   marker_bbox_tracker dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_pix_valid     (pixValid),
      .i_x             (px),
      .i_y             (py),
      .i_R             (pr),
      .i_G             (pg),
      .i_B             (pb),
      .i_frame_end     (frameEnd),
      .o_left          (oLeft),
      .o_right         (oRight),
      .o_up            (oUp),
      .o_down          (oDown),
      .o_lost          (oLost),
      .o_predict_valid (oPredictValid)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: keep the raw list of matching pixels, derive the box at frame end.
   task automatic modelReset();
      for (int k = 0; k < 2; k++) begin
         mLeft[k] = DEF; mRight[k] = DEF; mUp[k] = DEF; mDown[k] = DEF;
         mMiss[k] = 0; mLost[k] = 0;
      end
      mPulse = 0;
      mSync  = 1'b1;
      qx0.delete(); qy0.delete(); qx1.delete(); qy1.delete();
   endtask

   task automatic modelCommit();
      for (int k = 0; k < 2; k++) begin
         int n;
         int lx, rx, uy, dy;
         n  = (k == 0) ? qx0.size() : qx1.size();
         lx = 100000; rx = -1; uy = 100000; dy = -1;
         for (int i = 0; i < n; i++) begin
            int xv, yv;
            xv = (k == 0) ? qx0[i] : qx1[i];
            yv = (k == 0) ? qy0[i] : qy1[i];
            if (xv < lx) lx = xv;
            if (xv > rx) rx = xv;
            if (yv < uy) uy = yv;
            if (yv > dy) dy = yv;
         end
         if (n >= MIN_PIX) begin
            mLeft[k] = lx; mRight[k] = rx; mUp[k] = uy; mDown[k] = dy;
            mMiss[k] = 0; mLost[k] = 0;
         end else if (mMiss[k] < LOST_FRAMES) begin
            mMiss[k]++;
            if (mMiss[k] == LOST_FRAMES) begin
               mLeft[k] = DEF; mRight[k] = DEF; mUp[k] = DEF; mDown[k] = DEF;
               mLost[k] = 1;
            end
         end
      end
      qx0.delete(); qy0.delete(); qx1.delete(); qy1.delete();
   endtask

   task automatic modelStep(input bit r, input bit v, input int x, input int y,
                            input int cr, input int cg, input int cb, input bit fe);
      if (r) begin
         modelReset();
      end else begin
         if (!mSync && v && x <= 639 && y <= 479) begin
            if (cr >= 160 && cg <= 90 && cb <= 90) begin
               qx0.push_back(x); qy0.push_back(y);
            end else if (cb >= 160 && cr <= 90 && cg <= 90) begin
               qx1.push_back(x); qy1.push_back(y);
            end
         end
         mPulse = 0;
         if (fe) begin
            if (mSync) begin
               mSync = 1'b0;
            end else begin
               modelCommit();
               mPulse = 1;
            end
         end
      end
   endtask

   task automatic checkOutput();
      for (int k = 0; k < 2; k++) begin
         checkVal($sformatf("left%0d", k),  int'(oLeft[k]),  mLeft[k]);
         checkVal($sformatf("right%0d", k), int'(oRight[k]), mRight[k]);
         checkVal($sformatf("up%0d", k),    int'(oUp[k]),    mUp[k]);
         checkVal($sformatf("down%0d", k),  int'(oDown[k]),  mDown[k]);
         checkVal($sformatf("lost%0d", k),  int'(oLost[k]),  mLost[k]);
      end
      checkVal("predict_valid", int'(oPredictValid), mPulse);
   endtask

   // One clock cycle: drive on the falling edge, compare just after the rising edge.
   task automatic applyStimulus(input bit r, input bit v, input int x, input int y,
                                input int cr, input int cg, input int cb, input bit fe);
      @(negedge clk);
      rst      = r;
      pixValid = v;
      px       = 11'(x);
      py       = 11'(y);
      pr       = 8'(cr);
      pg       = 8'(cg);
      pb       = 8'(cb);
      frameEnd = fe;
      @(posedge clk);
      #1;
      modelStep(r, v, x, y, cr, cg, cb, fe);
      checkOutput();
   endtask

   task automatic idle();
      applyStimulus(1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b0);
   endtask

   task automatic frameEndCycle();
      applyStimulus(1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b1);
   endtask

   task automatic pixel(input int color, input int x, input int y);
      if (color == 0) applyStimulus(1'b0, 1'b1, x, y, 200, 40, 60, 1'b0);
      else            applyStimulus(1'b0, 1'b1, x, y, 30, 70, 210, 1'b0);
   endtask

   task automatic sendBlock(input int color, input int x0, input int y0,
                            input int w, input int h, input int n);
      int sent;
      sent = 0;
      for (int j = 0; j < h; j++) begin
         for (int i = 0; i < w; i++) begin
            if (sent < n) begin
               pixel(color, x0 + i, y0 + j);
               sent++;
            end
         end
      end
   endtask

   task automatic randomColor(output int cr, output int cg, output int cb);
      case ($urandom_range(0, 5))
         0, 5: begin
            cr = $urandom_range(160, 255); cg = $urandom_range(0, 90); cb = $urandom_range(0, 90);
         end
         1: begin
            cb = $urandom_range(160, 255); cr = $urandom_range(0, 90); cg = $urandom_range(0, 90);
         end
         2: begin
            cr = 159 + $urandom_range(0, 1); cg = 90 + $urandom_range(0, 1); cb = 90 + $urandom_range(0, 1);
         end
         3: begin
            cb = 159 + $urandom_range(0, 1); cr = 90 + $urandom_range(0, 1); cg = 90 + $urandom_range(0, 1);
         end
         default: begin
            cr = $urandom_range(0, 255); cg = $urandom_range(0, 255); cb = $urandom_range(0, 255);
         end
      endcase
   endtask

   typedef struct {
      int color;
      int x0, y0, w, h, n;
      int eL, eR, eU, eD, eLost;
   } frameVec_t;

   frameVec_t tbl[5];

   initial begin
      tbl[0] = '{0, 100, 50, 20, 10, 200, 100, 119, 50, 59, 0};
      tbl[1] = '{0, 300, 300, 15, 1, 15, 100, 119, 50, 59, 0};
      tbl[2] = '{1, 10, 20, 16, 1, 16, 10, 25, 20, 20, 0};
      tbl[3] = '{0, 0, 0, 1, 16, 16, 0, 0, 0, 15, 0};
      tbl[4] = '{0, 630, 478, 10, 2, 20, 630, 639, 478, 479, 0};

      rst = 1'b1; pixValid = 1'b0; px = '0; py = '0;
      pr = '0; pg = '0; pb = '0; frameEnd = 1'b0;
      modelReset();

      applyStimulus(1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b0);
      applyStimulus(1'b1, 1'b0, 0, 0, 0, 0, 0, 1'b0);
      checkVal("reset_left0", int'(oLeft[0]), 200);
      checkVal("reset_lost", int'(oLost), 0);

      // Sync frame end produces no pulse
      frameEndCycle();
      checkVal("sync_no_pulse", int'(oPredictValid), 0);

      for (int t = 0; t < 5; t++) begin
         sendBlock(tbl[t].color, tbl[t].x0, tbl[t].y0, tbl[t].w, tbl[t].h, tbl[t].n);
         frameEndCycle();
         checkVal($sformatf("tbl%0d_pulse", t), int'(oPredictValid), 1);
         checkVal($sformatf("tbl%0d_left", t),  int'(oLeft[tbl[t].color]),  tbl[t].eL);
         checkVal($sformatf("tbl%0d_right", t), int'(oRight[tbl[t].color]), tbl[t].eR);
         checkVal($sformatf("tbl%0d_up", t),    int'(oUp[tbl[t].color]),    tbl[t].eU);
         checkVal($sformatf("tbl%0d_down", t),  int'(oDown[tbl[t].color]),  tbl[t].eD);
         checkVal($sformatf("tbl%0d_lost", t),  int'(oLost[tbl[t].color]),  tbl[t].eLost);
         if (t == 0) checkVal("tbl0_p1_left", int'(oLeft[1]), 200);
         idle();
         checkVal($sformatf("tbl%0d_pulse_gone", t), int'(oPredictValid), 0);
      end

      // Red and blue in the same frame, plus out-of-range and invalid pixels
      for (int i = 0; i < 20; i++) begin
         pixel(0, 100 + i, 50);
         pixel(1, 400 + (i % 10), 200 + (i / 10));
      end
      pixel(0, 700, 60);
      pixel(0, 120, 480);
      applyStimulus(1'b0, 1'b0, 5, 5, 200, 40, 60, 1'b0);
      frameEndCycle();
      checkVal("both_left0", int'(oLeft[0]), 100);
      checkVal("both_right0", int'(oRight[0]), 119);
      checkVal("both_down0", int'(oDown[0]), 50);
      checkVal("both_left1", int'(oLeft[1]), 400);
      checkVal("both_right1", int'(oRight[1]), 409);
      checkVal("both_down1", int'(oDown[1]), 201);

      // Four back-to-back empty frames lose both players
      for (int m = 1; m <= 4; m++) begin
         frameEndCycle();
         if (m == 3) begin
            checkVal("miss3_left0", int'(oLeft[0]), 100);
            checkVal("miss3_lost", int'(oLost), 0);
         end
      end
      checkVal("miss4_left0", int'(oLeft[0]), 200);
      checkVal("miss4_down1", int'(oDown[1]), 200);
      checkVal("miss4_lost", int'(oLost), 3);
      sendBlock(0, 50, 60, 4, 4, 16);
      frameEndCycle();
      checkVal("recover_lost", int'(oLost), 2);
      checkVal("recover_right0", int'(oRight[0]), 53);

      // Matching pixel in the frame-end cycle belongs to the ending frame
      sendBlock(0, 280, 10, 20, 1, 20);
      applyStimulus(1'b0, 1'b1, 300, 10, 200, 40, 60, 1'b1);
      checkVal("fe_pixel_right0", int'(oRight[0]), 300);
      checkVal("fe_pixel_pulse", int'(oPredictValid), 1);

      // Mid-frame reset returns to defaults and re-enters sync
      sendBlock(0, 10, 10, 8, 2, 16);
      applyStimulus(1'b1, 1'b1, 20, 20, 200, 40, 60, 1'b0);
      checkVal("midrst_left0", int'(oLeft[0]), 200);
      checkVal("midrst_pulse", int'(oPredictValid), 0);
      frameEndCycle();
      checkVal("midrst_sync_pulse", int'(oPredictValid), 0);
      sendBlock(1, 5, 6, 16, 1, 16);
      frameEndCycle();
      checkVal("midrst_after_left1", int'(oLeft[1]), 5);

      // Randomized frames checked every cycle against the model
      for (int f = 0; f < 40; f++) begin
         int npix;
         npix = $urandom_range(0, 70);
         for (int p = 0; p < npix; p++) begin
            int cr, cg, cb;
            bit lastFe;
            randomColor(cr, cg, cb);
            lastFe = (p == npix - 1) && ($urandom_range(0, 1) == 1);
            applyStimulus(1'b0, $urandom_range(0, 9) != 0, $urandom_range(0, 700),
                          $urandom_range(0, 520), cr, cg, cb, lastFe);
            if (lastFe) npix = 0;
         end
         if (npix != 0 || $urandom_range(0, 3) == 0) frameEndCycle();
         if ($urandom_range(0, 1) == 1) idle();
      end
      idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
